// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receive bit-sampling path.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_HOLD    = 2'd2
    } samp_state_e;

    localparam logic VOTE_MAJ = 1'b0;
    localparam logic VOTE_CTR = 1'b1;

    // Smallest prescale that leaves room for the sample window plus a decision cycle.
    function automatic int min_prescale(input int num_samples);
        return num_samples + 2;
    endfunction

endpackage

// File: rtl/uart_rx_multisampler_maj_vote.sv
// Combinational popcount/threshold and all-equal detector over the captured samples.
module maj_vote #(
    parameter int NUM_SAMPLES = 3
) (
    input  logic [NUM_SAMPLES-1:0] samples_i,
    output logic                   majority_o,
    output logic                   all_equal_o
);
    localparam int CW = $clog2(NUM_SAMPLES + 1);
    localparam int H  = (NUM_SAMPLES - 1) / 2;

    logic [CW-1:0] ones_s;

    // Count the ones among the captured samples.
    always_comb begin
        ones_s = '0;
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            ones_s = ones_s + CW'(samples_i[k]);
        end
    end

    assign majority_o  = (ones_s > CW'(H));
    assign all_equal_o = (samples_i == '0) || (samples_i == '1);

endmodule

// File: rtl/uart_rx_multisampler.sv
// Oversampling bit-decision block: captures a window of samples around the bit centre
// and resolves them to one bit with a strobe, a noise flag and a prescale legality flag.
module uart_rx_multisampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W     = 6,
    parameter int NUM_SAMPLES = 3,
    parameter int CNT_W       = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RX_IN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               data_samp_en,
    input  logic [PRESC_W-1:0] edge_cnt,
    input  logic               vote_mode,
    output logic               sampled_bit,
    output logic               sample_valid,
    output logic               noise_flag,
    output logic               cfg_err
);
    localparam int EW = PRESC_W + 1;
    localparam int H  = (NUM_SAMPLES - 1) / 2;
    localparam logic [EW-1:0]    HALF_W    = EW'(H);
    localparam logic [EW-1:0]    ONE_W     = EW'(1);
    localparam logic [EW-1:0]    MIN_PRESC = EW'(min_prescale(NUM_SAMPLES));
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] IDX_ONE   = CNT_W'(1);

    samp_state_e            state_q, state_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    logic [NUM_SAMPLES-1:0] samp_q, samp_d, samp_ins_s;
    logic                   pend_q, pend_d;
    logic                   bit_q, bit_d;
    logic                   valid_q, valid_d;
    logic                   noise_q, noise_d;

    logic [EW-1:0] presc_s, edge_s, target_s, last_edge_s;
    logic          at_target_s, at_last_s, maj_s, all_eq_s, decided_s;

    // Window arithmetic is one bit wider than prescale so nothing wraps.
    assign presc_s     = {1'b0, prescale};
    assign edge_s      = {1'b0, edge_cnt};
    assign target_s    = (presc_s >> 1) - HALF_W + EW'(idx_q);
    assign last_edge_s = presc_s - ONE_W;
    assign at_target_s = (edge_s == target_s);
    assign at_last_s   = (edge_s == last_edge_s);
    assign cfg_err     = (presc_s < MIN_PRESC);

    maj_vote #(
        .NUM_SAMPLES (NUM_SAMPLES)
    ) u_maj_vote (
        .samples_i   (samp_q),
        .majority_o  (maj_s),
        .all_equal_o (all_eq_s)
    );

    assign decided_s = (vote_mode == VOTE_CTR) ? samp_q[H] : maj_s;

    // Sample register with RX_IN written into the slot addressed by idx.
    always_comb begin
        for (int k = 0; k < NUM_SAMPLES; k++) begin
            samp_ins_s[k] = (idx_q == CNT_W'(k)) ? RX_IN : samp_q[k];
        end
    end

    // Next-state and output decision logic.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        samp_d  = samp_q;
        pend_d  = 1'b0;
        bit_d   = bit_q;
        valid_d = 1'b0;
        noise_d = 1'b0;
        if (!data_samp_en || cfg_err) begin
            // Disable or illegal window discards any in-flight bit, even a pending decision.
            state_d = ST_IDLE;
            idx_d   = '0;
            samp_d  = '0;
            bit_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_COLLECT;
                    idx_d   = '0;
                    samp_d  = '0;
                end
                ST_COLLECT: begin
                    if (at_last_s) begin
                        // Counter skipped a sample point: decide on what we have and rearm.
                        bit_d   = decided_s;
                        valid_d = 1'b1;
                        noise_d = 1'b1;
                        idx_d   = '0;
                        samp_d  = '0;
                    end else if (at_target_s) begin
                        samp_d = samp_ins_s;
                        idx_d  = idx_q + IDX_ONE;
                        if (idx_q == LAST_IDX) begin
                            state_d = ST_HOLD;
                            pend_d  = 1'b1;
                        end else begin
                            state_d = ST_COLLECT;
                        end
                    end else begin
                        state_d = ST_COLLECT;
                    end
                end
                ST_HOLD: begin
                    if (pend_q) begin
                        bit_d   = decided_s;
                        valid_d = 1'b1;
                        noise_d = !all_eq_s;
                    end else begin
                        bit_d = bit_q;
                    end
                    if (at_last_s) begin
                        state_d = ST_COLLECT;
                        idx_d   = '0;
                        samp_d  = '0;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    samp_d  = '0;
                    bit_d   = 1'b0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            samp_q  <= '0;
            pend_q  <= 1'b0;
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            noise_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            samp_q  <= samp_d;
            pend_q  <= pend_d;
            bit_q   <= bit_d;
            valid_q <= valid_d;
            noise_q <= noise_d;
        end
    end

    assign sampled_bit  = bit_q;
    assign sample_valid = valid_q;
    assign noise_flag   = noise_q;

endmodule
